priority_management: RTL and testbench

Free-entry allocator for the out-of-order core's buffer structures (reservation stations, ROB/LSQ slots). Given a vector of free-entry flags and an allocate request, it selects exactly one free entry as a one-hot grant plus its binary index, in the same cycle. Selection is fixed lowest-index-first by default. An optional round-robin mode rotates the search start after each grant.

---
 rtl/priority_management_if.sv | 46 ++++
 rtl/priority_management.sv | 84 ++++++++
 tb/tb_priority_management.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/priority_management_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_management_if
// Description : Request/grant bundle between a buffer-entry requester and the
//               free-entry allocator.
//               master : drives allocate_i / resource_valid_i, observes grant
//               slave  : the allocator; observes the request, drives the grant
// Ports       : allocate_i       - allocation request
//               resource_valid_i - per-entry free flags (bit k = entry k free)
//               entry_sel_o      - one-hot grant, zero when nothing granted
//               entry_idx_o      - binary index of the grant, zero when none
//               grant_valid_o    - a grant is being issued this cycle
//               none_free_o      - no entry is free
// Revision    : 1.0 - initial release
// ============================================================================
interface priority_management_if #(
    parameter int N = 4
);
    localparam int c_IDX_W = $clog2(N);

    logic               allocate_i;
    logic [N-1:0]       resource_valid_i;
    logic [N-1:0]       entry_sel_o;
    logic [c_IDX_W-1:0] entry_idx_o;
    logic               grant_valid_o;
    logic               none_free_o;

    modport master (
        output allocate_i,
        output resource_valid_i,
        input  entry_sel_o,
        input  entry_idx_o,
        input  grant_valid_o,
        input  none_free_o
    );

    modport slave (
        input  allocate_i,
        input  resource_valid_i,
        output entry_sel_o,
        output entry_idx_o,
        output grant_valid_o,
        output none_free_o
    );
endinterface
`default_nettype wire

// File: rtl/priority_management.sv
`default_nettype none
// ============================================================================
// Module      : priority_management
// Description : Same-cycle free-entry allocator. Picks one free entry out of
//               N as a one-hot grant plus binary index. RR_EN = 0 gives fixed
//               lowest-index-first priority; RR_EN = 1 rotates the search
//               start to just past the last granted entry.
// Ports       : clk_i - clock, rising edge
//               rst_i - synchronous active-high reset
//               bus   - priority_management_if.slave (request in, grant out)
// Revision    : 1.0 - initial release
// ============================================================================
module priority_management #(
    parameter int N     = 4,
    parameter bit RR_EN = 1'b0
) (
    input  wire                          clk_i,
    input  wire                          rst_i,
    priority_management_if.slave         bus
);
    localparam int             c_IDX_W = $clog2(N);
    localparam logic [N-1:0]   c_ONE   = {{(N-1){1'b0}}, 1'b1};

    // Search start pointer; only ever leaves zero in round-robin mode.
    logic [c_IDX_W-1:0] ptr_q;
    logic [c_IDX_W-1:0] ptr_d;

    logic [2*N-1:0]     w_mask;
    logic [2*N-1:0]     w_dbl;
    logic               w_found;
    logic [c_IDX_W-1:0] w_pick_idx;
    logic               w_grant;

    // Double-width masked priority encode: the free vector is repeated twice
    // and every position below ptr is masked off. The lowest surviving bit
    // is the first free entry in the order ptr..N-1, 0..ptr-1; positions in
    // the upper copy fold back by subtracting N, so the wrap is modulo N
    // even when N is not a power of two.
    always_comb begin
        w_mask     = '0;
        w_found    = 1'b0;
        w_pick_idx = '0;
        for (int i = 0; i < 2*N; i++) begin
            w_mask[i] = (i >= int'(ptr_q));
        end
        w_dbl = {bus.resource_valid_i, bus.resource_valid_i} & w_mask;
        for (int i = 0; i < 2*N; i++) begin
            if (!w_found && w_dbl[i]) begin
                w_found    = 1'b1;
                w_pick_idx = (i < N) ? c_IDX_W'(i) : c_IDX_W'(i - N);
            end
        end
    end

    // Reset suppresses the grant combinationally in the same cycle.
    assign w_grant = bus.allocate_i & ~rst_i & w_found;

    assign bus.entry_sel_o   = w_grant ? (c_ONE << w_pick_idx) : '0;
    assign bus.entry_idx_o   = w_grant ? w_pick_idx : '0;
    assign bus.grant_valid_o = w_grant;
    assign bus.none_free_o   = ~|bus.resource_valid_i;

    always_comb begin
        ptr_d = ptr_q;
        if (!RR_EN) begin
            ptr_d = '0;
        end else if (w_grant) begin
            if (w_pick_idx == c_IDX_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = w_pick_idx + c_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_priority_management.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_management
// Description : Directed bench for priority_management. One fixed-priority
//               and one round-robin instance (N = 4) run side by side; each
//               step pushes expected grant outputs onto a per-instance queue
//               and pops them when the outputs are sampled mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_management;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    priority_management_if #(.N(N)) if_fx ();
    priority_management_if #(.N(N)) if_rr ();

    priority_management #(.N(N), .RR_EN(1'b0)) u_fx (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_fx.slave)
    );

    priority_management #(.N(N), .RR_EN(1'b1)) u_rr (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if_rr.slave)
    );

    typedef struct {
        string        tag;
        logic [N-1:0] sel;
        logic [1:0]   idx;
        logic         gv;
        logic         nf;
    } exp_t;

    exp_t q_fx[$];
    exp_t q_rr[$];

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;   // reference round-robin pointer

    // Reference: walk start, start+1, ... modulo N and take the first free.
    function automatic int ref_pick(logic [N-1:0] rv, int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (rv[j]) return j;
        end
        return -1;
    endfunction

    function automatic exp_t make_exp(string tag, logic r, logic a, logic [N-1:0] rv, int start);
        exp_t e;
        int   j;
        e.tag = tag;
        e.sel = '0;
        e.idx = '0;
        e.gv  = 1'b0;
        e.nf  = (rv == '0);
        j = ref_pick(rv, start);
        if (a && !r && j >= 0) begin
            e.sel[j] = 1'b1;
            e.idx    = 2'(j);
            e.gv     = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (q_fx.size() == 0 || q_rr.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=1", q_fx.size());
            return;
        end
        e = q_fx.pop_front();
        chk({e.tag, "/fx/sel"}, 32'(if_fx.entry_sel_o),   32'(e.sel));
        chk({e.tag, "/fx/idx"}, 32'(if_fx.entry_idx_o),   32'(e.idx));
        chk({e.tag, "/fx/gv"},  32'(if_fx.grant_valid_o), 32'(e.gv));
        chk({e.tag, "/fx/nf"},  32'(if_fx.none_free_o),   32'(e.nf));
        e = q_rr.pop_front();
        chk({e.tag, "/rr/sel"}, 32'(if_rr.entry_sel_o),   32'(e.sel));
        chk({e.tag, "/rr/idx"}, 32'(if_rr.entry_idx_o),   32'(e.idx));
        chk({e.tag, "/rr/gv"},  32'(if_rr.grant_valid_o), 32'(e.gv));
        chk({e.tag, "/rr/nf"},  32'(if_rr.none_free_o),   32'(e.nf));
    endtask

    // One cycle: drive just after the rising edge, sample at the falling
    // edge, then advance the reference pointer as the next edge will.
    task automatic step(string tag, logic r,
                        logic a_fx, logic [N-1:0] rv_fx,
                        logic a_rr, logic [N-1:0] rv_rr);
        int j;
        @(posedge clk);
        #1;
        rst                    = r;
        if_fx.allocate_i       = a_fx;
        if_fx.resource_valid_i = rv_fx;
        if_rr.allocate_i       = a_rr;
        if_rr.resource_valid_i = rv_rr;
        q_fx.push_back(make_exp(tag, r, a_fx, rv_fx, 0));
        q_rr.push_back(make_exp(tag, r, a_rr, rv_rr, m_ptr));
        @(negedge clk);
        check_pop();
        j = ref_pick(rv_rr, m_ptr);
        if (r) m_ptr = 0;
        else if (a_rr && j >= 0) m_ptr = (j + 1) % N;
    endtask

    initial begin
        if_fx.allocate_i       = 1'b1;
        if_fx.resource_valid_i = 4'b1111;
        if_rr.allocate_i       = 1'b1;
        if_rr.resource_valid_i = 4'b1111;

        // Reset: grants suppressed, none_free still follows the free flags.
        step("rst0", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111);
        step("rst1", 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000);

        // Fixed-priority table; round-robin instance idles (pointer holds).
        step("fx0", 1'b0, 1'b0, 4'b1111, 1'b0, 4'b1111);
        step("fx1", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b1111);
        step("fx2", 1'b0, 1'b1, 4'b0011, 1'b0, 4'b1111);
        step("fx3", 1'b0, 1'b1, 4'b0100, 1'b0, 4'b1111);
        step("fx4", 1'b0, 1'b1, 4'b0110, 1'b0, 4'b1111);
        step("fx5", 1'b0, 1'b0, 4'b1110, 1'b0, 4'b1111);
        step("fx6", 1'b0, 1'b1, 4'b1110, 1'b0, 4'b1111);
        step("fx7", 1'b0, 1'b1, 4'b1100, 1'b0, 4'b1111);
        step("fx8", 1'b0, 1'b0, 4'b1111, 1'b0, 4'b1111);

        // All busy with a request pending.
        step("busy", 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000);

        // Round-robin sweep from 0 with wrap.
        step("rr0", 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);
        step("rr1", 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);
        step("rr2", 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);
        step("rr3", 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);
        step("rr4", 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);

        // ptr = 1 -> grant 1, ptr = 2; then skip-and-wrap on 0011.
        step("rr5",   1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);
        step("skip0", 1'b0, 1'b1, 4'b0011, 1'b1, 4'b0011);
        step("skip1", 1'b0, 1'b1, 4'b0011, 1'b1, 4'b0011);

        // Hold: no requests for three cycles, pointer must not move.
        step("hold0", 1'b0, 1'b0, 4'b1111, 1'b0, 4'b1111);
        step("hold1", 1'b0, 1'b0, 4'b1111, 1'b0, 4'b1111);
        step("hold2", 1'b0, 1'b0, 4'b1111, 1'b0, 4'b1111);
        step("hold3", 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);

        // Sparse free vectors around the wrap point.
        step("sp0", 1'b0, 1'b1, 4'b1001, 1'b1, 4'b1001);
        step("sp1", 1'b0, 1'b1, 4'b0110, 1'b1, 4'b0110);
        step("sp2", 1'b0, 1'b1, 4'b1000, 1'b1, 4'b0001);
        step("sp3", 1'b0, 1'b1, 4'b1010, 1'b1, 4'b1010);

        // Reset mid-stream with a live request, then restart from entry 0.
        step("mrst", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1111);
        step("post", 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);
        step("post1", 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
